// File: rtl/inj_scan_seq_core.sv
// inj_scan_seq_core
// Mask-scan sequencer. For every mask step it kicks an SPI configuration
// shift, waits for it to finish, strobes pixel load, idles for a settle time,
// then fires a train of injection pulses, each followed by a delayed trigger
// pulse. Injection trains pause while the readout FIFO is full.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   START               one-cycle pulse; starts a scan and latches CONF_*
//   ABORT               level; returns to IDLE from any active state
//   CONF_MASK_STEPS     mask steps per scan (0 behaves as 1)
//   CONF_INJ_REPEAT     injections per step (0 = none)
//   CONF_INJ_PERIOD     cycles between injection starts
//   CONF_TRIG_DELAY     cycles from INJ_START to TRIG_START
//   CONF_SETTLE         idle cycles between LD_PULSE and first injection
//   SPI_START/SPI_DONE  handshake with the SPI master
//   LD_PULSE            pixel load strobe
//   INJ_START           start pulse for the injection pulse generator
//   TRIG_START          start pulse for the trigger pulse generator
//   FIFO_FULL           readout backpressure
//   BUSY, DONE          status; DONE pulses on normal completion only
//   MASK_STEP           current step index (0-based)
//   INJ_COUNT           injections completed in the current step
module inj_scan_seq_core #(
  parameter int STEP_W = 8,
  parameter int INJ_W  = 16,
  parameter int DLY_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              ABORT,
  input  logic [STEP_W-1:0] CONF_MASK_STEPS,
  input  logic [INJ_W-1:0]  CONF_INJ_REPEAT,
  input  logic [DLY_W-1:0]  CONF_INJ_PERIOD,
  input  logic [DLY_W-1:0]  CONF_TRIG_DELAY,
  input  logic [DLY_W-1:0]  CONF_SETTLE,
  output logic              SPI_START,
  input  logic              SPI_DONE,
  output logic              LD_PULSE,
  output logic              INJ_START,
  output logic              TRIG_START,
  input  logic              FIFO_FULL,
  output logic              BUSY,
  output logic              DONE,
  output logic [STEP_W-1:0] MASK_STEP,
  output logic [INJ_W-1:0]  INJ_COUNT
);

  typedef enum logic [3:0] {
    S_IDLE, S_CONF, S_WAIT_SPI, S_LOAD, S_SETTLE, S_INJ, S_HOLD, S_NEXT, S_FINISH
  } state_t;

  state_t            state;
  logic [STEP_W-1:0] steps_eff;
  logic [INJ_W-1:0]  inj_rep;
  logic [DLY_W-1:0]  period_last;  // last phase value of one injection period
  logic [DLY_W-1:0]  trig_dly;
  logic [DLY_W-1:0]  settle;
  logic [DLY_W-1:0]  settle_cnt;
  logic [DLY_W-1:0]  phase;

  // Effective period is max(PERIOD, TRIG_DELAY+1) so every trigger lands
  // inside its own injection period; stored as period-1 to keep DLY_W bits.
  logic [DLY_W:0]    trig_p1;
  logic [DLY_W-1:0]  conf_period_last;
  assign trig_p1          = {1'b0, CONF_TRIG_DELAY} + (DLY_W+1)'(1);
  assign conf_period_last = ({1'b0, CONF_INJ_PERIOD} > trig_p1) ?
                            CONF_INJ_PERIOD - DLY_W'(1) : CONF_TRIG_DELAY;

  logic [INJ_W-1:0]  inj_cnt_nxt;
  logic [DLY_W-1:0]  phase_inc;
  logic              step_last;
  assign inj_cnt_nxt = INJ_COUNT + INJ_W'(1);
  assign phase_inc   = phase + DLY_W'(1);
  // One extra bit so the last step of a full-range scan cannot wrap.
  assign step_last   = ({1'b0, MASK_STEP} + (STEP_W+1)'(1)) == {1'b0, steps_eff};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_IDLE;
      steps_eff   <= '0;
      inj_rep     <= '0;
      period_last <= '0;
      trig_dly    <= '0;
      settle      <= '0;
      settle_cnt  <= '0;
      phase       <= '0;
      SPI_START   <= 1'b0;
      LD_PULSE    <= 1'b0;
      INJ_START   <= 1'b0;
      TRIG_START  <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      MASK_STEP   <= '0;
      INJ_COUNT   <= '0;
    end else begin
      // Pulse outputs are high only in the cycle the FSM enters the
      // corresponding state/phase.
      SPI_START  <= 1'b0;
      LD_PULSE   <= 1'b0;
      INJ_START  <= 1'b0;
      TRIG_START <= 1'b0;
      DONE       <= 1'b0;
      if (ABORT && state != S_IDLE) begin
        state <= S_IDLE;
        BUSY  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (START && !ABORT) begin
            steps_eff   <= (CONF_MASK_STEPS == '0) ? STEP_W'(1) : CONF_MASK_STEPS;
            inj_rep     <= CONF_INJ_REPEAT;
            period_last <= conf_period_last;
            trig_dly    <= CONF_TRIG_DELAY;
            settle      <= CONF_SETTLE;
            MASK_STEP   <= '0;
            INJ_COUNT   <= '0;
            BUSY        <= 1'b1;
            SPI_START   <= 1'b1;
            state       <= S_CONF;
          end
          S_CONF: state <= S_WAIT_SPI;
          S_WAIT_SPI: if (SPI_DONE) begin
            LD_PULSE <= 1'b1;
            state    <= S_LOAD;
          end
          S_LOAD: begin
            settle_cnt <= settle;
            if (settle != '0) begin
              state <= S_SETTLE;
            end else if (inj_rep == '0) begin
              state <= S_NEXT;
            end else begin
              state      <= S_INJ;
              phase      <= '0;
              INJ_START  <= 1'b1;
              TRIG_START <= (trig_dly == '0);
            end
          end
          S_SETTLE: begin
            // Entered with settle_cnt = settle, so this state lasts exactly
            // `settle` cycles.
            if (settle_cnt != DLY_W'(1)) begin
              settle_cnt <= settle_cnt - DLY_W'(1);
            end else if (inj_rep == '0) begin
              state <= S_NEXT;
            end else begin
              state      <= S_INJ;
              phase      <= '0;
              INJ_START  <= 1'b1;
              TRIG_START <= (trig_dly == '0);
            end
          end
          S_INJ: begin
            if (phase == period_last) begin
              INJ_COUNT <= inj_cnt_nxt;
              if (inj_cnt_nxt == inj_rep) begin
                state <= S_NEXT;
              end else if (FIFO_FULL) begin
                state <= S_HOLD;
              end else begin
                phase      <= '0;
                INJ_START  <= 1'b1;
                TRIG_START <= (trig_dly == '0);
              end
            end else begin
              // FIFO_FULL is only looked at on period boundaries, so a
              // trigger already owed is never dropped.
              phase      <= phase_inc;
              TRIG_START <= (phase_inc == trig_dly);
            end
          end
          S_HOLD: if (!FIFO_FULL) begin
            state      <= S_INJ;
            phase      <= '0;
            INJ_START  <= 1'b1;
            TRIG_START <= (trig_dly == '0);
          end
          S_NEXT: begin
            INJ_COUNT <= '0;
            if (step_last) begin
              DONE  <= 1'b1;
              state <= S_FINISH;
            end else begin
              MASK_STEP <= MASK_STEP + STEP_W'(1);
              SPI_START <= 1'b1;
              state     <= S_CONF;
            end
          end
          S_FINISH: begin
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inj_scan_seq_core.sv
// Directed bench for inj_scan_seq_core. A responder answers each SPI_START
// with SPI_DONE 20 cycles later; a monitor logs the cycle of every pulse.
module tb_inj_scan_seq_core;
  localparam int STEP_W = 8;
  localparam int INJ_W  = 16;
  localparam int DLY_W  = 16;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              START = 1'b0;
  logic              ABORT = 1'b0;
  logic              SPI_DONE = 1'b0;
  logic              FIFO_FULL = 1'b0;
  logic [STEP_W-1:0] CONF_MASK_STEPS = '0;
  logic [INJ_W-1:0]  CONF_INJ_REPEAT = '0;
  logic [DLY_W-1:0]  CONF_INJ_PERIOD = '0;
  logic [DLY_W-1:0]  CONF_TRIG_DELAY = '0;
  logic [DLY_W-1:0]  CONF_SETTLE = '0;
  logic              SPI_START, LD_PULSE, INJ_START, TRIG_START, BUSY, DONE;
  logic [STEP_W-1:0] MASK_STEP;
  logic [INJ_W-1:0]  INJ_COUNT;

  inj_scan_seq_core #(.STEP_W(STEP_W), .INJ_W(INJ_W), .DLY_W(DLY_W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
    .CONF_MASK_STEPS(CONF_MASK_STEPS), .CONF_INJ_REPEAT(CONF_INJ_REPEAT),
    .CONF_INJ_PERIOD(CONF_INJ_PERIOD), .CONF_TRIG_DELAY(CONF_TRIG_DELAY),
    .CONF_SETTLE(CONF_SETTLE), .SPI_START(SPI_START), .SPI_DONE(SPI_DONE),
    .LD_PULSE(LD_PULSE), .INJ_START(INJ_START), .TRIG_START(TRIG_START),
    .FIFO_FULL(FIFO_FULL), .BUSY(BUSY), .DONE(DONE),
    .MASK_STEP(MASK_STEP), .INJ_COUNT(INJ_COUNT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int q_spi[$], q_ld[$], q_inj[$], q_trig[$], q_done[$];
  always @(negedge CLK) begin
    if (SPI_START)  q_spi.push_back(cyc);
    if (LD_PULSE)   q_ld.push_back(cyc);
    if (INJ_START)  q_inj.push_back(cyc);
    if (TRIG_START) q_trig.push_back(cyc);
    if (DONE)       q_done.push_back(cyc);
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (SPI_START) begin
        repeat (20) @(posedge CLK);
        #1 SPI_DONE = 1'b1;
        @(posedge CLK);
        #1 SPI_DONE = 1'b0;
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic clear_q();
    q_spi.delete(); q_ld.delete(); q_inj.delete(); q_trig.delete(); q_done.delete();
  endtask

  task automatic run_scan(input int steps, input int rep, input int per,
                          input int dly, input int settle);
    CONF_MASK_STEPS = STEP_W'(steps);
    CONF_INJ_REPEAT = INJ_W'(rep);
    CONF_INJ_PERIOD = DLY_W'(per);
    CONF_TRIG_DELAY = DLY_W'(dly);
    CONF_SETTLE     = DLY_W'(settle);
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int k = 0;
    while (q_done.size() == 0 && k < budget) begin tick(); k++; end
    ok = (q_done.size() != 0);
    tick(2);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(3);
    n_chk++;
    if ({SPI_START, LD_PULSE, INJ_START, TRIG_START, BUSY, DONE} !== 6'b0) begin
      n_fail++; $display("FAIL reset_pulses: got %b want 000000",
                         {SPI_START, LD_PULSE, INJ_START, TRIG_START, BUSY, DONE});
    end
    n_chk++;
    if (MASK_STEP !== '0 || INJ_COUNT !== '0) begin
      n_fail++; $display("FAIL reset_counters: got step=%0d cnt=%0d want 0/0", MASK_STEP, INJ_COUNT);
    end
    RST = 1'b0;
    tick(2);
  endtask

  task automatic test_basic();
    bit ok;
    clear_q();
    run_scan(2, 3, 10, 4, 5);
    wait_done(600, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL basic_done_timeout: got no DONE want DONE"); end
    n_chk++;
    if (q_spi.size() != 2 || q_ld.size() != 2 || q_inj.size() != 6 ||
        q_trig.size() != 6 || q_done.size() != 1) begin
      n_fail++; $display("FAIL basic_counts: got spi=%0d ld=%0d inj=%0d trig=%0d done=%0d want 2/2/6/6/1",
                         q_spi.size(), q_ld.size(), q_inj.size(), q_trig.size(), q_done.size());
    end else begin
      for (int s = 0; s < 2; s++) begin
        n_chk++;
        if (q_ld[s] - q_spi[s] != 21) begin
          n_fail++; $display("FAIL basic_spi_to_ld[%0d]: got %0d want 21", s, q_ld[s] - q_spi[s]);
        end
        for (int j = 0; j < 3; j++) begin
          n_chk++;
          if (q_inj[3*s+j] - q_ld[s] != 6 + 10*j) begin
            n_fail++; $display("FAIL basic_inj_time[%0d]: got %0d want %0d",
                               3*s+j, q_inj[3*s+j] - q_ld[s], 6 + 10*j);
          end
          n_chk++;
          if (q_trig[3*s+j] - q_inj[3*s+j] != 4) begin
            n_fail++; $display("FAIL basic_trig_delay[%0d]: got %0d want 4",
                               3*s+j, q_trig[3*s+j] - q_inj[3*s+j]);
          end
        end
      end
      n_chk++;
      if (q_spi[1] - q_ld[0] != 37) begin
        n_fail++; $display("FAIL basic_step_gap: got %0d want 37", q_spi[1] - q_ld[0]);
      end
      n_chk++;
      if (q_done[0] - q_ld[1] != 37) begin
        n_fail++; $display("FAIL basic_done_time: got %0d want 37", q_done[0] - q_ld[1]);
      end
    end
    n_chk++;
    if (BUSY !== 1'b0 || MASK_STEP !== 8'd1 || INJ_COUNT !== 16'd0) begin
      n_fail++; $display("FAIL basic_end_state: got busy=%b step=%0d cnt=%0d want 0/1/0",
                         BUSY, MASK_STEP, INJ_COUNT);
    end
  endtask

  task automatic test_long_delay();
    bit ok;
    clear_q();
    run_scan(1, 2, 5, 12, 0);
    wait_done(300, ok);
    n_chk++;
    if (!ok || q_inj.size() != 2 || q_trig.size() != 2 || q_ld.size() != 1) begin
      n_fail++; $display("FAIL longdly_counts: got done=%0d inj=%0d trig=%0d want 1/2/2",
                         ok, q_inj.size(), q_trig.size());
    end else begin
      n_chk++;
      if (q_inj[0] - q_ld[0] != 1) begin
        n_fail++; $display("FAIL longdly_first_inj: got %0d want 1", q_inj[0] - q_ld[0]);
      end
      n_chk++;
      if (q_inj[1] - q_inj[0] != 13) begin
        n_fail++; $display("FAIL longdly_spacing: got %0d want 13", q_inj[1] - q_inj[0]);
      end
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (q_trig[i] - q_inj[i] != 12) begin
          n_fail++; $display("FAIL longdly_trig[%0d]: got %0d want 12", i, q_trig[i] - q_inj[i]);
        end
      end
      n_chk++;
      if (q_done[0] - q_ld[0] != 28) begin
        n_fail++; $display("FAIL longdly_done_time: got %0d want 28", q_done[0] - q_ld[0]);
      end
    end
  endtask

  task automatic test_zero_delay();
    bit ok;
    clear_q();
    run_scan(1, 2, 3, 0, 2);
    wait_done(300, ok);
    n_chk++;
    if (!ok || q_inj.size() != 2 || q_trig.size() != 2 || q_ld.size() != 1) begin
      n_fail++; $display("FAIL zerodly_counts: got done=%0d inj=%0d trig=%0d want 1/2/2",
                         ok, q_inj.size(), q_trig.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (q_inj[i] - q_ld[0] != 3 + 3*i) begin
          n_fail++; $display("FAIL zerodly_inj[%0d]: got %0d want %0d", i, q_inj[i] - q_ld[0], 3 + 3*i);
        end
        n_chk++;
        if (q_trig[i] != q_inj[i]) begin
          n_fail++; $display("FAIL zerodly_same_cycle[%0d]: got trig=%0d want %0d", i, q_trig[i], q_inj[i]);
        end
      end
    end
  endtask

  task automatic test_fifo_hold();
    bit ok;
    int ld, k;
    int exp_inj[4];
    clear_q();
    run_scan(1, 4, 10, 4, 1);
    k = 0;
    while (q_ld.size() == 0 && k < 100) begin tick(); k++; end
    n_chk++;
    if (q_ld.size() == 0) begin
      n_fail++; $display("FAIL fifo_ld_timeout: got no LD_PULSE want LD_PULSE");
    end else begin
      ld = q_ld[0];
      k = 0;
      while (cyc != ld + 14 && k < 50) begin tick(); k++; end
      FIFO_FULL = 1'b1;
      tick(30);
      FIFO_FULL = 1'b0;
      wait_done(300, ok);
      exp_inj[0] = ld + 2; exp_inj[1] = ld + 12; exp_inj[2] = ld + 45; exp_inj[3] = ld + 55;
      n_chk++;
      if (!ok || q_inj.size() != 4 || q_trig.size() != 4) begin
        n_fail++; $display("FAIL fifo_counts: got done=%0d inj=%0d trig=%0d want 1/4/4",
                           ok, q_inj.size(), q_trig.size());
      end else begin
        for (int i = 0; i < 4; i++) begin
          n_chk++;
          if (q_inj[i] != exp_inj[i]) begin
            n_fail++; $display("FAIL fifo_inj_time[%0d]: got %0d want %0d", i, q_inj[i], exp_inj[i]);
          end
          n_chk++;
          if (q_trig[i] != exp_inj[i] + 4) begin
            n_fail++; $display("FAIL fifo_trig_time[%0d]: got %0d want %0d", i, q_trig[i], exp_inj[i] + 4);
          end
        end
        n_chk++;
        if (q_done[0] != ld + 66) begin
          n_fail++; $display("FAIL fifo_done_time: got %0d want %0d", q_done[0], ld + 66);
        end
      end
    end
  endtask

  task automatic test_abort();
    bit ok;
    int k;
    clear_q();
    run_scan(3, 1, 2, 1, 0);
    k = 0;
    while (q_spi.size() < 2 && k < 200) begin tick(); k++; end
    tick(5);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    n_chk++;
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", BUSY); end
    n_chk++;
    if (MASK_STEP !== 8'd1) begin n_fail++; $display("FAIL abort_step: got %0d want 1", MASK_STEP); end
    tick(30);
    n_chk++;
    if (q_done.size() != 0 || q_spi.size() != 2 || q_ld.size() != 1) begin
      n_fail++; $display("FAIL abort_quiet: got done=%0d spi=%0d ld=%0d want 0/2/1",
                         q_done.size(), q_spi.size(), q_ld.size());
    end
    clear_q();
    run_scan(3, 1, 2, 1, 0);
    wait_done(400, ok);
    n_chk++;
    if (!ok || q_spi.size() != 3 || q_ld.size() != 3 || q_inj.size() != 3 || q_done.size() != 1) begin
      n_fail++; $display("FAIL abort_rescan: got done=%0d spi=%0d ld=%0d inj=%0d want 1/3/3/3",
                         ok, q_spi.size(), q_ld.size(), q_inj.size());
    end
    n_chk++;
    if (MASK_STEP !== 8'd2 || BUSY !== 1'b0) begin
      n_fail++; $display("FAIL abort_rescan_end: got step=%0d busy=%b want 2/0", MASK_STEP, BUSY);
    end
  endtask

  task automatic test_no_inj();
    bit ok;
    clear_q();
    run_scan(0, 0, 4, 1, 3);
    tick(3);
    CONF_SETTLE = DLY_W'(50);
    CONF_MASK_STEPS = 8'd4;
    START = 1'b1;
    tick();
    START = 1'b0;
    wait_done(200, ok);
    n_chk++;
    if (!ok || q_spi.size() != 1 || q_ld.size() != 1 || q_inj.size() != 0 ||
        q_trig.size() != 0 || q_done.size() != 1) begin
      n_fail++; $display("FAIL noinj_counts: got done=%0d spi=%0d ld=%0d inj=%0d trig=%0d want 1/1/1/0/0",
                         ok, q_spi.size(), q_ld.size(), q_inj.size(), q_trig.size());
    end else begin
      n_chk++;
      if (q_done[0] - q_ld[0] != 5) begin
        n_fail++; $display("FAIL noinj_done_time: got %0d want 5", q_done[0] - q_ld[0]);
      end
    end
    n_chk++;
    if (MASK_STEP !== 8'd0) begin n_fail++; $display("FAIL noinj_step: got %0d want 0", MASK_STEP); end
  endtask

  task automatic test_reset_mid();
    int k;
    clear_q();
    run_scan(2, 3, 10, 4, 5);
    k = 0;
    while (q_inj.size() < 2 && k < 200) begin tick(); k++; end
    RST = 1'b1;
    #1;
    n_chk++;
    if (BUSY !== 1'b0 || INJ_COUNT !== '0 || MASK_STEP !== '0) begin
      n_fail++; $display("FAIL midrst_state: got busy=%b cnt=%0d step=%0d want 0/0/0",
                         BUSY, INJ_COUNT, MASK_STEP);
    end
    tick(2);
    RST = 1'b0;
    clear_q();
    tick(40);
    n_chk++;
    if (q_spi.size() + q_ld.size() + q_inj.size() + q_trig.size() + q_done.size() != 0) begin
      n_fail++; $display("FAIL midrst_quiet: got %0d pulses want 0",
                         q_spi.size() + q_ld.size() + q_inj.size() + q_trig.size() + q_done.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_long_delay();
    test_zero_delay();
    test_fifo_hold();
    test_abort();
    test_no_inj();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
